// File: rtl/multirate_v2_fir_mac_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multirate_v2_fir_mac_seq_pkg
// Description : Shared types and widths for the sequential decimating FIR MAC.
// Revision    : 1.0 - initial release
// ============================================================================
package multirate_v2_fir_mac_seq_pkg;

  localparam int DIN_W  = 16;
  localparam int COEF_W = 8;
  localparam int PROD_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  // Accumulator wide enough to add NTAPS full-scale products without overflow
  function automatic int calc_acc_w(input int ntaps);
    return PROD_W + $clog2(ntaps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multirate_v2_fir_mac_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : Multirate_v2_mul_16s_8s_24_1_1
// Description : Combinational signed multiplier, 16s x 8s -> 24s.
// Revision    : 1.0 - initial release
// ============================================================================
module Multirate_v2_mul_16s_8s_24_1_1
  import multirate_v2_fir_mac_seq_pkg::*;
(
  input  logic signed [DIN_W-1:0]  din0_i,
  input  logic signed [COEF_W-1:0] din1_i,
  output logic signed [PROD_W-1:0] dout_o
);

  // Both operands signed, so the product is sign-extended to the 24-bit result
  assign dout_o = din0_i * din1_i;

endmodule
`default_nettype wire

// File: rtl/multirate_v2_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : multirate_v2_fir_mac_seq
// Description : Decimating FIR filter, one shared multiplier, one tap per
//               cycle. Accepts DECIM samples, then runs NTAPS MAC cycles and
//               holds the result until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module multirate_v2_fir_mac_seq
  import multirate_v2_fir_mac_seq_pkg::*;
#(
  parameter int NTAPS = 16,
  parameter int DECIM = 2,
  parameter int ACC_W = calc_acc_w(NTAPS)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [DIN_W-1:0]         s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [ACC_W-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     busy
);

  localparam int K_W  = $clog2(NTAPS);
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic signed [DIN_W-1:0]  x_q    [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];

  state_e                   state_q;
  logic [K_W-1:0]           k_q;
  logic [PH_W-1:0]          phase_q;
  logic [PH_W-1:0]          phase_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic                     s_ready_q;
  logic                     m_valid_q;
  logic                     busy_q;

  logic                     accept;
  logic                     phase_last;
  logic                     tap_last;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // s_ready_q is high exactly in IDLE, so it doubles as the "in IDLE" flag
  assign accept     = s_valid && s_ready_q;
  assign phase_last = (phase_q == PH_W'(DECIM - 1));
  assign tap_last   = (k_q == K_W'(NTAPS - 1));

  Multirate_v2_mul_16s_8s_24_1_1 u_mul (
    .din0_i (x_q[k_q]),
    .din1_i (coef_q[k_q]),
    .dout_o (prod)
  );

  // Next phase and accumulator values; tap 0 loads rather than adds
  always_comb begin
    phase_d  = phase_last ? '0 : phase_q + PH_W'(1);
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    acc_d    = (k_q == '0) ? prod_ext : acc_q + prod_ext;
  end

  // Sample delay line: shift on every accepted input
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NTAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= s_data;
      for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Coefficient RAM: writable only while idle so a running sum stays consistent
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else if (coef_we && (state_q == ST_IDLE)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      phase_q   <= '0;
      acc_q     <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            phase_q <= phase_d;
            if (phase_last) begin
              state_q   <= ST_MAC;
              k_q       <= '0;
              s_ready_q <= 1'b0;
              busy_q    <= 1'b1;
            end
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          if (tap_last) begin
            state_q   <= ST_OUT;
            k_q       <= '0;
            m_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          k_q       <= '0;
          s_ready_q <= 1'b1;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign m_data  = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_multirate_v2_fir_mac_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multirate_v2_fir_mac_seq
// Description : Directed bench for the decimating FIR MAC. Instance A runs
//               with DECIM=1, instance B with DECIM=2; shared stimulus is
//               steered to one of them by cur.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multirate_v2_fir_mac_seq;

  localparam int NTAPS = 16;
  localparam int ACC_W = 28;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               ap_rst_n;
  logic               cur;
  logic signed [15:0] s_data;
  logic               s_valid;
  logic               m_ready;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic [7:0]         coef_data;

  logic               a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_coef_we, a_busy;
  logic               b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_coef_we, b_busy;
  logic [ACC_W-1:0]   a_m_data, b_m_data;

  assign a_s_valid = s_valid & ~cur;
  assign b_s_valid = s_valid &  cur;
  assign a_m_ready = cur ? 1'b1 : m_ready;
  assign b_m_ready = cur ? m_ready : 1'b1;
  assign a_coef_we = coef_we & ~cur;
  assign b_coef_we = coef_we &  cur;

  logic             o_s_ready, o_m_valid, o_busy;
  logic [ACC_W-1:0] o_m_data;
  assign o_s_ready = cur ? b_s_ready : a_s_ready;
  assign o_m_valid = cur ? b_m_valid : a_m_valid;
  assign o_busy    = cur ? b_busy    : a_busy;
  assign o_m_data  = cur ? b_m_data  : a_m_data;

  multirate_v2_fir_mac_seq #(.NTAPS(NTAPS), .DECIM(1), .ACC_W(ACC_W)) u_dut_a (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .s_data    (s_data),
    .s_valid   (a_s_valid),
    .s_ready   (a_s_ready),
    .m_data    (a_m_data),
    .m_valid   (a_m_valid),
    .m_ready   (a_m_ready),
    .coef_we   (a_coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (a_busy)
  );

  multirate_v2_fir_mac_seq #(.NTAPS(NTAPS), .DECIM(2), .ACC_W(ACC_W)) u_dut_b (
    .ap_clk    (clk),
    .ap_rst_n  (ap_rst_n),
    .s_data    (s_data),
    .s_valid   (b_s_valid),
    .s_ready   (b_s_ready),
    .m_data    (b_m_data),
    .m_valid   (b_m_valid),
    .m_ready   (b_m_ready),
    .coef_we   (b_coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (b_busy)
  );

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint mdata_s();
    return longint'($signed(o_m_data));
  endfunction

  // All tasks start and end at a falling edge
  task automatic write_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = 8'(val);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic send(input int val);
    s_valid = 1'b1;
    s_data  = 16'(val);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, let it be consumed.
  // exp_lat > 0 also checks falling edges counted from the accepting edge.
  task automatic get(input longint exp, input string tag, input int exp_lat);
    int lat;
    lat = 1;
    m_ready = 1'b1;
    while (!o_m_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!o_m_valid) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check(tag, mdata_s(), exp);
      if (exp_lat > 0) check({tag, "_lat"}, lat, exp_lat);
      @(negedge clk);
    end
  endtask

  initial begin
    int bad;
    int cnt;
    longint held;
    n_tests   = 0;
    n_fail    = 0;
    cur       = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    ap_rst_n  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_m_valid", o_m_valid, 0);
    check("rst_busy",    o_busy,    0);
    check("rst_m_data",  mdata_s(), 0);
    ap_rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", o_s_ready, 1);
    check("post_rst_m_valid", o_m_valid, 0);

    // Decimation by 2, all coefficients 1: cumulative window sums
    cur = 1'b1;
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
    send(1);
    check("dec_odd_busy",    o_busy,    0);
    check("dec_odd_s_ready", o_s_ready, 1);
    send(2); get(3,  "dec_out0", NTAPS + 1);
    send(3); send(4); get(10, "dec_out1", NTAPS + 1);
    send(5); send(6); get(21, "dec_out2", NTAPS + 1);
    send(7); send(8); get(36, "dec_out3", NTAPS + 1);

    // Impulse response with coef[k] = k+1
    cur = 1'b0;
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    send(1);
    get(1, "imp_0", NTAPS + 1);
    for (int k = 1; k < NTAPS; k++) begin
      send(0);
      get(longint'(k + 1), $sformatf("imp_%0d", k), 0);
    end

    // Full-scale extremes: -128 * -32768 summed over a growing window
    for (int k = 0; k < NTAPS; k++) write_coef(k, -128);
    for (int k = 0; k < NTAPS; k++) begin
      send(-32768);
      get(longint'(k + 1) * 64'sd4194304, $sformatf("ext_%0d", k), 0);
    end

    // Backpressure: result held for 20 cycles with m_ready low
    m_ready = 1'b0;
    send(-32768);
    cnt = 0;
    while (!o_m_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_value", mdata_s(), 64'sd67108864);
    held = mdata_s();
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mdata_s() != held || o_s_ready !== 1'b0 || o_m_valid !== 1'b1 || o_busy !== 1'b1)
        bad++;
    end
    check("bp_hold", bad, 0);
    m_ready = 1'b1;
    check("bp_release_s_ready", o_s_ready, 0);
    @(negedge clk);
    check("bp_after_m_valid", o_m_valid, 0);
    check("bp_after_s_ready", o_s_ready, 1);

    // Coefficient write during MAC must be ignored
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
    send(5);
    @(negedge clk);
    @(negedge clk);
    write_coef(0, 100);
    get(-64'sd491515, "freeze_cur", 0);
    send(2);
    get(-64'sd458745, "freeze_next", 0);

    // Reset in the middle of MAC (tap 5) aborts the computation
    send(7);
    repeat (5) @(negedge clk);
    ap_rst_n = 1'b0;
    #1;
    check("abort_busy",    o_busy,    0);
    check("abort_m_valid", o_m_valid, 0);
    @(negedge clk);
    ap_rst_n = 1'b1;
    @(negedge clk);
    check("abort_s_ready", o_s_ready, 1);
    check("abort_m_data",  mdata_s(), 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (o_m_valid) cnt++;
    end
    check("abort_no_output", cnt, 0);

    // Impulse again: coefficients were cleared by reset
    send(1);
    get(0, "zimp_0", NTAPS + 1);
    for (int k = 1; k < NTAPS; k++) begin
      send(0);
      get(0, $sformatf("zimp_%0d", k), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
